// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage.
// Covers store-data source select codes, FSM state encodings and the M/W register bundle.
package mem_stage_pkg;

  localparam logic [1:0] SDEP_MQB  = 2'b00;
  localparam logic [1:0] SDEP_WFWD = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic [4:0]  rd;
    logic [31:0] mo;
    logic [31:0] alu;
    logic        err;
  } mw_bundle_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_w_reg.sv
// M/W pipeline register: enable-gated flip-flop cells, one per field width.
// Synchronous active-high clear takes priority over the enable.
module mem_dffe #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clrn)    q <= '0;
    else if (en) q <= d;
  end

endmodule

module mem_w_reg
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       en,
  input  mw_bundle_t d,
  output mw_bundle_t q
);

  mem_dffe #(.W(1))  u_wreg  (.clk(clk), .clrn(clrn), .en(en), .d(d.wreg),  .q(q.wreg));
  mem_dffe #(.W(1))  u_m2reg (.clk(clk), .clrn(clrn), .en(en), .d(d.m2reg), .q(q.m2reg));
  mem_dffe #(.W(5))  u_rd    (.clk(clk), .clrn(clrn), .en(en), .d(d.rd),    .q(q.rd));
  mem_dffe #(.W(32)) u_mo    (.clk(clk), .clrn(clrn), .en(en), .d(d.mo),    .q(q.mo));
  mem_dffe #(.W(32)) u_alu   (.clk(clk), .clrn(clrn), .en(en), .d(d.alu),   .q(q.alu));
  mem_dffe #(.W(1))  u_err   (.clk(clk), .clrn(clrn), .en(en), .d(d.err),   .q(q.err));

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack access with timeout, stall generation and M/W register.
// state   | meaning
// ST_IDLE | no access outstanding; a new access may complete in its first cycle
// ST_WAIT | request held high, waiting for dmem_ack or the timeout count
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [4:0]  mrd,
  input  logic [31:0] mresult,
  input  logic [31:0] mqb,
  input  logic [1:0]  msdepend,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wrd,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [31:0] wdi,
  output logic        werr
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  mem_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          access, misalign, go;
  logic          ack_done, timeout, err;
  mw_bundle_t    w_d, w_q;

  assign access   = mm2reg | mwmem;
  assign misalign = access & is_misaligned(mresult);
  assign go       = access & ~misalign;

  always_ff @(posedge clk) begin
    if (clrn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    ack_done  = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        dmem_req = go;
        if (go && dmem_ack) begin
          ack_done = 1'b1;
        end else if (go) begin
          mem_stall = 1'b1;
          state_nxt = ST_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      ST_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          ack_done  = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Reset silences the bus and releases upstream in the same cycle.
    if (clrn) begin
      dmem_req  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  assign err        = misalign | timeout;
  assign dmem_we    = dmem_req & mwmem;
  assign dmem_addr  = mresult;
  assign dmem_wdata = (msdepend == SDEP_WFWD) ? wdi : mqb;

  always_comb begin
    w_d       = '0;
    w_d.wreg  = mwreg & ~err;
    w_d.m2reg = mm2reg;
    w_d.rd    = mrd;
    w_d.mo    = (mm2reg & ack_done) ? dmem_rdata : 32'h0;
    w_d.alu   = mresult;
    w_d.err   = err;
  end

  mem_w_reg u_w_reg (
    .clk  (clk),
    .clrn (clrn),
    .en   (~mem_stall),
    .d    (w_d),
    .q    (w_q)
  );

  assign wwreg  = w_q.wreg;
  assign wm2reg = w_q.m2reg;
  assign wrd    = w_q.rd;
  assign wmo    = w_q.mo;
  assign walu   = w_q.alu;
  assign werr   = w_q.err;
  assign wdi    = w_q.m2reg ? w_q.mo : w_q.alu;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios then random instruction mix.
// The driver predicts each instruction's W result and bus timing; a monitor checks every W load.
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mwreg, mm2reg, mwmem;
  logic [4:0]  mrd;
  logic [31:0] mresult, mqb;
  logic [1:0]  msdepend;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall;
  logic        wwreg, wm2reg, werr;
  logic [4:0]  wrd;
  logic [31:0] wmo, walu, wdi;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clrn(clrn), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mrd(mrd), .mresult(mresult), .mqb(mqb), .msdepend(msdepend),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wwreg(wwreg), .wm2reg(wm2reg), .wrd(wrd),
    .wmo(wmo), .walu(walu), .wdi(wdi), .werr(werr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  wrd;
    logic [31:0] wmo;
    logic [31:0] walu;
    logic [31:0] wdi;
    logic        werr;
  } wexp_t;

  wexp_t       expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_wdi = 32'h0;
  logic        load_pending = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a W load happens on every edge where the stage was not stalled and not in reset.
  always @(negedge clk) begin
    if (load_pending) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wload: W register loaded with no expected entry at %0t", $time);
      end else begin
        wexp_t e;
        e = expq.pop_front();
        chk("wwreg",  32'(wwreg),  32'(e.wwreg));
        chk("wm2reg", 32'(wm2reg), 32'(e.wm2reg));
        chk("wrd",    32'(wrd),    32'(e.wrd));
        chk("wmo",    wmo,         e.wmo);
        chk("walu",   walu,        e.walu);
        chk("wdi",    wdi,         e.wdi);
        chk("werr",   32'(werr),   32'(e.werr));
      end
    end
    load_pending = !mem_stall && !clrn;
  end

  // lat: request cycle (0-based) in which ack is given; >= TIMEOUT means never.
  // rst_at: cycle in which reset is asserted to abandon the instruction (-1: none).
  task automatic run_instr(input logic wreg, input logic m2reg, input logic wmem,
                           input logic [4:0] rd, input logic [31:0] res, input logic [31:0] qb,
                           input logic [1:0] sdep, input logic [31:0] rdata,
                           input int lat, input bit late_ack, input int rst_at);
    bit          acc, mis, g, tmo, done;
    int          reqs, stalls, cyc;
    wexp_t       e;
    logic [31:0] pre_wdi, exp_wdata;
    acc       = m2reg || wmem;
    mis       = acc && (res[1:0] != 2'b00);
    g         = acc && !mis;
    tmo       = g && (lat >= TIMEOUT);
    pre_wdi   = m_wdi;
    exp_wdata = (sdep == 2'b01) ? pre_wdi : qb;
    e.werr    = mis || tmo;
    e.wwreg   = wreg && !e.werr;
    e.wm2reg  = m2reg;
    e.wrd     = rd;
    e.walu    = res;
    e.wmo     = (m2reg && g && !tmo) ? rdata : 32'h0;
    e.wdi     = e.wm2reg ? e.wmo : e.walu;
    if (rst_at < 0) begin
      expq.push_back(e);
      m_wdi = e.wdi;
    end else begin
      m_wdi = 32'h0;
    end
    reqs = 0; stalls = 0; cyc = 0; done = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      clrn       = (cyc == rst_at);
      mwreg      = wreg;
      mm2reg     = m2reg;
      mwmem      = wmem;
      mrd        = rd;
      mresult    = res;
      mqb        = qb;
      msdepend   = sdep;
      dmem_ack   = late_ack || (g && cyc == lat);
      dmem_rdata = (g && cyc == lat) ? rdata : $urandom;
      @(negedge clk);
      if (clrn) begin
        chk("rst_req",   32'(dmem_req),  32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_wwreg", 32'(wwreg), 32'h0);
        chk("rst_wrd",   32'(wrd),   32'h0);
        chk("rst_wmo",   wmo,        32'h0);
        chk("rst_walu",  walu,       32'h0);
        chk("rst_wdi",   wdi,        32'h0);
        chk("rst_werr",  32'(werr),  32'h0);
        return;
      end
      if (dmem_req) begin
        reqs++;
        chk("dmem_we",    32'(dmem_we), 32'(wmem));
        chk("dmem_addr",  dmem_addr,    res);
        chk("dmem_wdata", dmem_wdata,   exp_wdata);
      end
      chk("wdi_hold", wdi, pre_wdi);
      if (mem_stall) stalls++;
      else done = 1;
      cyc++;
      if (!done && cyc > TIMEOUT + 4) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stall_bound: still stalled after %0d cycles, required release by %0d", cyc, TIMEOUT);
        done = 1;
      end
    end
    chk("req_cycles",   32'(reqs),   g ? (tmo ? 32'(TIMEOUT) : 32'(lat + 1)) : 32'h0);
    chk("stall_cycles", 32'(stalls), g ? (tmo ? 32'(TIMEOUT - 1) : 32'(lat)) : 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b1; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0; mrd = 5'd0;
    mresult = 32'h0; mqb = 32'h0; msdepend = 2'b00; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req",   32'(dmem_req),  32'h0);
    chk("reset_stall", 32'(mem_stall), 32'h0);
    chk("reset_wwreg", 32'(wwreg),     32'h0);
    chk("reset_wdi",   wdi,            32'h0);
    chk("reset_werr",  32'(werr),      32'h0);

    // zero-wait load
    run_instr(1'b1, 1'b1, 1'b0, 5'd5, 32'h100, 32'h0, 2'b00, 32'hDEADBEEF, 0, 1'b0, -1);
    // ALU op leaves walu = 0x1234 for forwarding
    run_instr(1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0, 2'b00, 32'h0, 0, 1'b0, -1);
    // three-wait store forwarding W data
    run_instr(1'b0, 1'b0, 1'b1, 5'd0, 32'h200, 32'hAAAA5555, 2'b01, 32'h0, 3, 1'b0, -1);
    // load never acked: timeout
    run_instr(1'b1, 1'b1, 1'b0, 5'd9, 32'h300, 32'h0, 2'b00, 32'h11112222, NEVER, 1'b0, -1);
    // late ack under a non-access instruction must be ignored
    run_instr(1'b1, 1'b0, 1'b0, 5'd4, 32'h77, 32'h0, 2'b00, 32'h0, 0, 1'b1, -1);
    // misaligned store
    run_instr(1'b1, 1'b0, 1'b1, 5'd2, 32'h102, 32'h5, 2'b00, 32'h0, 0, 1'b0, -1);
    // plain ALU op
    run_instr(1'b1, 1'b0, 1'b0, 5'd7, 32'h55, 32'h0, 2'b00, 32'h0, 0, 1'b0, -1);
    // ack in the last allowed cycle
    run_instr(1'b1, 1'b1, 1'b0, 5'd6, 32'h404, 32'h0, 2'b00, 32'hCAFEF00D, TIMEOUT - 1, 1'b0, -1);
    // reset in the second WAIT cycle
    run_instr(1'b1, 1'b1, 1'b0, 5'd8, 32'h400, 32'h0, 2'b00, 32'h12345678, NEVER, 1'b0, 2);

    for (int i = 0; i < 150; i++) begin
      int          kind, r, lat;
      logic        m2r, wm;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      m2r  = (kind == 0);
      wm   = (kind == 1);
      a    = $urandom;
      if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 19);
      if (r == 0)      lat = NEVER;
      else if (r == 1) lat = TIMEOUT - 1;
      else             lat = $urandom_range(0, 4);
      run_instr(1'($urandom_range(0, 1)), m2r, wm, 5'($urandom_range(0, 31)), a, $urandom,
                2'($urandom_range(0, 3)), $urandom, lat, 1'b0, -1);
    end

    @(posedge clk);
    #1;
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
